// File: rtl/vga_fb_fetch.sv
// Frame-buffer pixel fetch behind the VGA timing generator: power-of-two upscaled
// read addressing, blanked RGB output and sync delayed to match the RAM read latency.
module vga_fb_fetch #(
  parameter int unsigned HEN      = 800,
  parameter int unsigned VEN      = 600,
  parameter int unsigned FB_W     = 200,
  parameter int unsigned FB_H     = 150,
  parameter int unsigned SCALE_SH = 2,
  parameter int unsigned AW       = 15,
  parameter int unsigned DW       = 12,
  parameter int unsigned RD_LAT   = 1
) (
  input  logic          pclk,
  input  logic          rst,
  input  logic          hen,
  input  logic          ven,
  input  logic          hs,
  input  logic          vs,
  input  logic [DW-1:0] rdata,
  output logic [AW-1:0] raddr,
  output logic          rd_en,
  output logic [DW-1:0] rgb,
  output logic          hs_o,
  output logic          vs_o,
  output logic          frame_start
);

  localparam int unsigned L  = 1 + RD_LAT;
  localparam int unsigned SW = (SCALE_SH > 0) ? SCALE_SH : 1;
  localparam logic [SW-1:0] SUB_MAX  = SW'((1 << SCALE_SH) - 1);
  localparam logic [AW-1:0] ROW_STEP = AW'(FB_W);

  if (HEN != (FB_W << SCALE_SH) || VEN != (FB_H << SCALE_SH)) begin : g_geom_err
    $error("vga_fb_fetch: display size is not the frame buffer scaled by 2**SCALE_SH");
  end
  if (RD_LAT < 1 || RD_LAT > 3) begin : g_lat_err
    $error("vga_fb_fetch: RD_LAT must be 1..3");
  end

  typedef struct packed {
    logic hs;
    logic vs;
    logic dv;
    logic fs;
  } tap_t;

  logic          de;
  logic          de_q;
  logic          first;
  logic          locked;
  logic [AW-1:0] ptr;
  logic [AW-1:0] line_base;
  logic [SW-1:0] x_sub;
  logic [SW-1:0] y_sub;
  tap_t          pipe [L];

  always_comb begin
    de = hen & ven;
  end

  // Address generation: horizontal replication within a line, row replication across lines.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      de_q      <= 1'b0;
      first     <= 1'b0;
      locked    <= 1'b0;
      ptr       <= '0;
      line_base <= '0;
      x_sub     <= '0;
      y_sub     <= '0;
    end else begin
      de_q <= de;
      if (!ven) begin
        ptr       <= '0;
        line_base <= '0;
        x_sub     <= '0;
        y_sub     <= '0;
        first     <= 1'b1;
        locked    <= 1'b1;
      end else if (de) begin
        first <= 1'b0;
        if (x_sub == SUB_MAX) begin
          x_sub <= '0;
          ptr   <= ptr + AW'(1);
        end else begin
          x_sub <= x_sub + SW'(1);
        end
      end else if (de_q) begin
        x_sub <= '0;
        if (y_sub == SUB_MAX) begin
          y_sub     <= '0;
          line_base <= line_base + ROW_STEP;
          ptr       <= line_base + ROW_STEP;
        end else begin
          y_sub <= y_sub + SW'(1);
          ptr   <= line_base;
        end
      end
    end
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      raddr <= '0;
      rd_en <= 1'b0;
    end else begin
      rd_en <= de & locked;
      if (de) begin
        raddr <= ptr;
      end
    end
  end

  // Sync and pixel-valid taps run L stages so they land on the same edge as rgb.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < L; i++) begin
        pipe[i] <= '0;
      end
    end else begin
      pipe[0] <= '{hs: hs, vs: vs, dv: de & locked, fs: de & first & locked};
      for (int unsigned i = 1; i < L; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      rgb         <= '0;
      hs_o        <= 1'b0;
      vs_o        <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      rgb         <= pipe[L-1].dv ? rdata : '0;
      hs_o        <= pipe[L-1].hs;
      vs_o        <= pipe[L-1].vs;
      frame_start <= pipe[L-1].fs;
    end
  end

endmodule
